// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// RAW hazard controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
// A three-entry scoreboard (EX, MEM, WB) mirrors the destination registers of
// the instructions in flight. The instruction in ID is compared against it to
// decide whether to stall IF/ID and bubble ID/EX. The block also produces
// registered operand-forwarding selects for the EX stage.
//
// Parameters
//   FORWARD_EN   1 = forward EX operands from MEM/WB (only load-use stalls)
//                0 = no forwarding, stall until the producer reaches WB
//   CNT_W        width of the saturating stall-cycle counter
//
// Ports
//   clk           core clock, all state updates on the rising edge
//   reset         asynchronous active-low reset, clears all state
//   pipe_en       pipeline advance enable; low freezes all state
//   id_valid      ID holds a real instruction (0 = bubble)
//   id_rs/id_rt   ID source registers
//   id_use_rs/rt  ID instruction actually reads rs / rt
//   id_dst        ID destination register
//   id_wr         ID instruction writes the register file
//   id_load       ID instruction is a load
//   pc_hold       hold PC this cycle (combinational)
//   ifid_hold     hold IF/ID register this cycle (combinational)
//   idex_bubble   load a bubble into ID/EX this cycle (combinational)
//   ex_fwd_a/b    EX operand selects: 00 regfile, 10 MEM result, 01 WB result
//   stall_cycles  number of advancing cycles spent stalled (saturating)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter bit FORWARD_EN = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_en,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_wr,
  input  logic             id_load,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic [1:0]       ex_fwd_a,
  output logic [1:0]       ex_fwd_b,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       load;
    logic [4:0] dst;
  } sb_entry_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b01;

  localparam sb_entry_t ENTRY_EMPTY = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  sb_entry_t        ex_q,  ex_d;
  sb_entry_t        mem_q, mem_d;
  sb_entry_t        wb_q,  wb_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic stall;
  logic issue;
  logic rs_ex, rt_ex, rs_mem, rt_mem;

  // A source only matches a real producer; $0 is hard-wired and never hazards.
  function automatic logic src_match(input sb_entry_t e,
                                     input logic      use_src,
                                     input logic [4:0] src);
    return use_src && (src != 5'd0) && e.valid && e.wr && (e.dst == src);
  endfunction

  // Newest producer wins: a non-load in EX has its result sitting in the
  // MEM stage once the consumer reaches EX, so it outranks the older MEM
  // entry (which will be in WB by then).
  function automatic logic [1:0] fwd_sel(input logic m_ex,
                                         input logic m_mem,
                                         input logic ex_is_load);
    logic [1:0] sel;
    sel = SEL_RF;
    if (FORWARD_EN) begin
      if (m_ex && !ex_is_load) begin
        sel = SEL_MEM;
      end else if (m_mem) begin
        sel = SEL_WB;
      end
    end
    return sel;
  endfunction

  // Hazard detection. The WB entry is never compared: the register file is
  // written before it is read, so a WB producer is already visible in ID.
  always_comb begin
    rs_ex  = src_match(ex_q,  id_use_rs, id_rs);
    rt_ex  = src_match(ex_q,  id_use_rt, id_rt);
    rs_mem = src_match(mem_q, id_use_rs, id_rs);
    rt_mem = src_match(mem_q, id_use_rt, id_rt);

    stall = 1'b0;
    if (id_valid) begin
      if (FORWARD_EN) begin
        stall = (rs_ex || rt_ex) && ex_q.load;
      end else begin
        stall = rs_ex || rt_ex || rs_mem || rt_mem;
      end
    end

    issue = id_valid && !stall;
  end

  // Next-state for scoreboard, forwarding selects and stall counter.
  always_comb begin
    ex_d           = ex_q;
    mem_d          = mem_q;
    wb_d           = wb_q;
    fwd_a_d        = fwd_a_q;
    fwd_b_d        = fwd_b_q;
    stall_cycles_d = stall_cycles_q;

    if (pipe_en) begin
      wb_d  = mem_q;
      mem_d = ex_q;

      if (issue) begin
        ex_d.valid = 1'b1;
        ex_d.wr    = id_wr;
        ex_d.load  = id_load;
        ex_d.dst   = id_dst;
        fwd_a_d    = fwd_sel(rs_ex, rs_mem, ex_q.load);
        fwd_b_d    = fwd_sel(rt_ex, rt_mem, ex_q.load);
      end else begin
        ex_d    = ENTRY_EMPTY;
        fwd_a_d = SEL_RF;
        fwd_b_d = SEL_RF;
      end

      if (stall && (stall_cycles_q != CNT_MAX)) begin
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q           <= ENTRY_EMPTY;
      mem_q          <= ENTRY_EMPTY;
      wb_q           <= ENTRY_EMPTY;
      fwd_a_q        <= SEL_RF;
      fwd_b_q        <= SEL_RF;
      stall_cycles_q <= '0;
    end else begin
      ex_q           <= ex_d;
      mem_q          <= mem_d;
      wb_q           <= wb_d;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // The WB entry and the MEM load bit are tracked to keep the scoreboard a
  // faithful image of the pipe, but no decision depends on them.
  logic unused_sb;
  assign unused_sb = ^{wb_q, mem_q.load};

  assign pc_hold      = stall;
  assign ifid_hold    = stall;
  assign idex_bubble  = stall;
  assign ex_fwd_a     = fwd_a_q;
  assign ex_fwd_b     = fwd_b_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Two instances share the ID-stage stimulus: u_fwd (FORWARD_EN=1, 32-bit
// counter) and u_nofwd (FORWARD_EN=0, 2-bit counter so saturation is reachable).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       pipe_en;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_use_rs, id_use_rt, id_wr, id_load;

  logic        ph1, ih1, bb1;
  logic [1:0]  fa1, fb1;
  logic [31:0] cnt1;
  logic        ph0, ih0, bb0;
  logic [1:0]  fa0, fb0;
  logic [1:0]  cnt0;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FORWARD_EN(1'b1), .CNT_W(32)) u_fwd (
    .clk(clk), .reset(reset), .pipe_en(pipe_en), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load),
    .pc_hold(ph1), .ifid_hold(ih1), .idex_bubble(bb1),
    .ex_fwd_a(fa1), .ex_fwd_b(fb1), .stall_cycles(cnt1)
  );

  hazard_ctrl #(.FORWARD_EN(1'b0), .CNT_W(2)) u_nofwd (
    .clk(clk), .reset(reset), .pipe_en(pipe_en), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load),
    .pc_hold(ph0), .ifid_hold(ih0), .idex_bubble(bb0),
    .ex_fwd_a(fa0), .ex_fwd_b(fb0), .stall_cycles(cnt0)
  );

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic wr, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_wr = wr; id_load = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    pipe_en = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; pipe_en = 1'b1;
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    tests++;
    if ({ph1, ih1, bb1, fa1, fb1} !== 7'b0) begin
      failed++; $display("FAIL reset_fwd_outs: got %b expected 0000000", {ph1, ih1, bb1, fa1, fb1});
    end
    tests++;
    if (cnt1 !== 32'd0) begin
      failed++; $display("FAIL reset_fwd_cnt: got %0d expected 0", cnt1);
    end
    tests++;
    if ({ph0, ih0, bb0, fa0, fb0, cnt0} !== 9'b0) begin
      failed++; $display("FAIL reset_nofwd_outs: got %b expected 000000000", {ph0, ih0, bb0, fa0, fb0, cnt0});
    end
    reset = 1'b1;
    #1;
  endtask

  // addi $10,$0,10 / addi $12,$0,11 / add $11,$12,$10
  task automatic test_fwd_alu();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd12, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    tests++;
    if ({ph1, ih1, bb1} !== 3'b000) begin
      failed++; $display("FAIL fwd_alu_nostall: got %b expected 000", {ph1, ih1, bb1});
    end
    tick();
    tests++;
    if (fa1 !== 2'b10) begin
      failed++; $display("FAIL fwd_alu_a: got %b expected 10", fa1);
    end
    tests++;
    if (fb1 !== 2'b01) begin
      failed++; $display("FAIL fwd_alu_b: got %b expected 01", fb1);
    end
    tests++;
    if (cnt1 !== 32'd0) begin
      failed++; $display("FAIL fwd_alu_cnt: got %0d expected 0", cnt1);
    end
  endtask

  // lw $16,0($10) then add $17,$16,$16
  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd16, 5'd16, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0);
    tests++;
    if ({ph1, ih1, bb1} !== 3'b111) begin
      failed++; $display("FAIL load_use_stall: got %b expected 111", {ph1, ih1, bb1});
    end
    tick();
    tests++;
    if ({ph1, ih1, bb1} !== 3'b000) begin
      failed++; $display("FAIL load_use_release: got %b expected 000", {ph1, ih1, bb1});
    end
    tests++;
    if ({fa1, fb1} !== 4'b0000) begin
      failed++; $display("FAIL load_use_bubble_sel: got %b expected 0000", {fa1, fb1});
    end
    tick();
    tests++;
    if ({fa1, fb1} !== 4'b0101) begin
      failed++; $display("FAIL load_use_sel: got %b expected 0101", {fa1, fb1});
    end
    tests++;
    if (cnt1 !== 32'd1) begin
      failed++; $display("FAIL load_use_cnt: got %0d expected 1", cnt1);
    end
  endtask

  task automatic test_no_fwd();
    do_reset();
    // addi $10 ; add $11,$10,$10 adjacent -> 2 stalls
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd10, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    tests++;
    if ({ph0, ih0, bb0} !== 3'b111) begin
      failed++; $display("FAIL nofwd_adj_stall1: got %b expected 111", {ph0, ih0, bb0});
    end
    tick();
    tests++;
    if ({ph0, ih0, bb0} !== 3'b111) begin
      failed++; $display("FAIL nofwd_adj_stall2: got %b expected 111", {ph0, ih0, bb0});
    end
    tick();
    tests++;
    if ({ph0, ih0, bb0} !== 3'b000) begin
      failed++; $display("FAIL nofwd_adj_release: got %b expected 000", {ph0, ih0, bb0});
    end
    tick();
    tests++;
    if ({fa0, fb0} !== 4'b0000) begin
      failed++; $display("FAIL nofwd_adj_sel: got %b expected 0000", {fa0, fb0});
    end
    tests++;
    if (cnt0 !== 2'd2) begin
      failed++; $display("FAIL nofwd_adj_cnt: got %0d expected 2", cnt0);
    end
    // addi $10 ; addi $5,$0,1 ; add $11,$10,$10 -> 1 stall
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    tests++;
    if ({ph0, ih0, bb0} !== 3'b000) begin
      failed++; $display("FAIL nofwd_indep: got %b expected 000", {ph0, ih0, bb0});
    end
    tick();
    set_id(1'b1, 5'd10, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    tests++;
    if ({ph0, ih0, bb0} !== 3'b111) begin
      failed++; $display("FAIL nofwd_gap_stall: got %b expected 111", {ph0, ih0, bb0});
    end
    tick();
    tests++;
    if ({ph0, ih0, bb0} !== 3'b000) begin
      failed++; $display("FAIL nofwd_gap_release: got %b expected 000", {ph0, ih0, bb0});
    end
    tests++;
    if (cnt0 !== 2'd3) begin
      failed++; $display("FAIL nofwd_gap_cnt: got %0d expected 3", cnt0);
    end
    // two more stall cycles: 2-bit counter must stay at 3
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd10, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    tick();
    tick();
    tests++;
    if (cnt0 !== 2'd3) begin
      failed++; $display("FAIL nofwd_saturate: got %0d expected 3", cnt0);
    end
  endtask

  task automatic test_zero_nop();
    do_reset();
    // addi $0,$0,5 ; add $1,$0,$0
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
    tests++;
    if ({ph1, ph0} !== 2'b00) begin
      failed++; $display("FAIL zero_reg_stall: got %b expected 00", {ph1, ph0});
    end
    tick();
    tests++;
    if ({fa1, fb1} !== 4'b0000) begin
      failed++; $display("FAIL zero_reg_sel: got %b expected 0000", {fa1, fb1});
    end
    // bubble that would have written $3, then a valid reader of $3
    set_id(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tests++;
    if ({ph1, ph0} !== 2'b00) begin
      failed++; $display("FAIL nop_producer_stall: got %b expected 00", {ph1, ph0});
    end
    tick();
    tests++;
    if ({fa1, fb1} !== 4'b0000) begin
      failed++; $display("FAIL nop_producer_sel: got %b expected 0000", {fa1, fb1});
    end
    // a real load, then a bubble in ID that names the loaded register
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    tests++;
    if ({ph1, ph0} !== 2'b00) begin
      failed++; $display("FAIL nop_consumer_stall: got %b expected 00", {ph1, ph0});
    end
    tick();
    tests++;
    if ({fa1, fb1, cnt1} !== 36'd0) begin
      failed++; $display("FAIL nop_consumer_state: got sel %b cnt %0d expected sel 0000 cnt 0", {fa1, fb1}, cnt1);
    end
  endtask

  task automatic test_pipe_freeze();
    do_reset();
    // addi $9 ; lw $16,0($9) (forwarded 10) ; add $17,$16,$16
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1);
    tick();
    tests++;
    if ({fa1, fb1} !== 4'b1000) begin
      failed++; $display("FAIL freeze_setup_sel: got %b expected 1000", {fa1, fb1});
    end
    set_id(1'b1, 5'd16, 5'd16, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0);
    pipe_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({ph1, ih1, bb1, fa1, fb1} !== 7'b1111000 || cnt1 !== 32'd0) begin
        failed++; $display("FAIL freeze_hold[%0d]: got stall/sel %b cnt %0d expected 1111000 cnt 0", i, {ph1, ih1, bb1, fa1, fb1}, cnt1);
      end
    end
    pipe_en = 1'b1;
    tick();
    tests++;
    if ({ph1, fa1, fb1} !== 5'b00000 || cnt1 !== 32'd1) begin
      failed++; $display("FAIL freeze_resume: got stall/sel %b cnt %0d expected 00000 cnt 1", {ph1, fa1, fb1}, cnt1);
    end
    tick();
    tests++;
    if ({fa1, fb1} !== 4'b0101 || cnt1 !== 32'd1) begin
      failed++; $display("FAIL freeze_consumer: got sel %b cnt %0d expected 0101 cnt 1", {fa1, fb1}, cnt1);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    // lw $16 ; add $17,$16,$16 : both instances stall on the first cycle
    set_id(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd16, 5'd16, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0);
    tests++;
    if ({ph1, ph0} !== 2'b11) begin
      failed++; $display("FAIL midrst_pre_stall: got %b expected 11", {ph1, ph0});
    end
    tick();
    tests++;
    if (ph0 !== 1'b1 || cnt0 !== 2'd1) begin
      failed++; $display("FAIL midrst_nofwd_stalling: got stall %b cnt %0d expected 1 cnt 1", ph0, cnt0);
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({ph0, ih0, bb0, fa0, fb0, cnt0} !== 9'b0 || cnt1 !== 32'd0) begin
      failed++; $display("FAIL midrst_async: got nofwd %b fwd cnt %0d expected 000000000 cnt 0", {ph0, ih0, bb0, fa0, fb0, cnt0}, cnt1);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({ph1, ih1, bb1, ph0, ih0, bb0} !== 6'b0) begin
      failed++; $display("FAIL midrst_after_release: got %b expected 000000", {ph1, ih1, bb1, ph0, ih0, bb0});
    end
    tick();
    tests++;
    if ({fa1, fb1} !== 4'b0000) begin
      failed++; $display("FAIL midrst_sel: got %b expected 0000", {fa1, fb1});
    end
  endtask

  initial begin
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_no_fwd();
    test_zero_nop();
    test_pipe_freeze();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core (IF, ID, EX, MEM, WB). It tracks the destination registers of instructions in flight and detects RAW hazards against the instruction in ID. It stalls IF/ID and inserts bubbles into ID/EX as needed, and drives registered operand-forwarding selects to the EX stage. With this block in place, programs no longer need hand-inserted NOPs between dependent instructions.

## Interface
Parameters:
- FORWARD_EN, 1, 1 = EX operands forwarded from MEM/WB; 0 = no forwarding, stall until producer reaches WB
- CNT_W, 32, width of stall-cycle counter

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- pipe_en  in  1  pipeline advance enable; low = freeze all state
- id_valid  in  1  ID holds a real instruction (0 = bubble/NOP)
- id_rs  in  5  ID source register rs
- id_rt  in  5  ID source register rt
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_dst  in  5  ID destination register (rd or rt per format)
- id_wr  in  1  ID instruction writes the register file
- id_load  in  1  ID instruction is lw/lh/lhu
- pc_hold  out  1  hold PC this cycle
- ifid_hold  out  1  hold IF/ID register this cycle
- idex_bubble  out  1  load a bubble into ID/EX this cycle
- ex_fwd_a  out  2  EX operand A select: 00 regfile, 10 MEM result, 01 WB result
- ex_fwd_b  out  2  EX operand B select, same encoding
- stall_cycles  out  CNT_W  count of cycles with stall asserted

## Operation
- Scoreboard: three entries EX, MEM, WB, each holding {valid, wr, load, dst}. An entry is a "producer" when valid && wr && dst != 0.
- Register file is write-before-read, so a WB producer never causes a hazard.
- Match: ID source rs (or rt) matches an entry when the corresponding use bit is set, the source != 0, and the entry is a producer with dst equal to that source.
- Stall when id_valid and any of the following holds:
  - FORWARD_EN=1: a source matches EX and EX.load = 1 (load-use).
  - FORWARD_EN=0: a source matches EX or MEM.
- stall drives pc_hold, ifid_hold and idex_bubble; all three are identical and combinational.
- Advance, on a rising edge with pipe_en=1:
  - WB <= MEM, MEM <= EX.
  - EX <= bubble (valid=0) if stall or !id_valid; otherwise EX <= {1, id_wr, id_load, id_dst}.
- Forward selects are registered and computed per source at the same advance (FORWARD_EN=1 only):
  - 10 if the source matches the pre-advance EX entry and that entry is not a load.
  - Else 01 if the source matches the pre-advance MEM entry.
  - Else 00.
  - EX has priority over MEM (newest value wins).
  - Forced to 00 on a bubble, and always 00 when FORWARD_EN=0.
- stall_cycles increments on each rising edge with pipe_en && stall. It saturates at all-ones.
- pipe_en=0: scoreboard, selects and counter hold. Stall outputs still reflect the current comparison.

## Timing
- Reset (async, reset=0): all entries invalid, ex_fwd_a/b=00, stall_cycles=0, so stall outputs are 0 while reset is held. Asserting reset mid-stall discards all in-flight state.
- Stall outputs are valid in the same cycle as the ID inputs (combinational, no latency).
- ex_fwd_a/b are valid during the cycle the instruction occupies EX, i.e. one edge after it leaves ID.
- Load-use with FORWARD_EN=1: exactly 1 stall cycle; the consumer then enters EX with select 01.
- FORWARD_EN=0: ALU producer followed by an adjacent consumer gives 2 stall cycles; one instruction between them gives 1 cycle.
- Bubbles and register $0 never cause a stall or a forward.
- Simultaneous rs and rt hazards produce a single stall; the selects are resolved independently.

## Test plan
- FORWARD_EN=1, sequence addi $10,$0,10 / addi $12,$0,11 / add $11,$12,$10 -> no stall; at add in EX, ex_fwd_a=10 (rs=$12 from MEM), ex_fwd_b=01 (rt=$10 from WB).
- FORWARD_EN=1, lw $16,0($10) then add $17,$16,$16 -> exactly one cycle with pc_hold=ifid_hold=idex_bubble=1; add in EX with ex_fwd_a=ex_fwd_b=01; stall_cycles=1.
- FORWARD_EN=0, addi $10 then add $11,$10,$10 -> 2 stall cycles, then ex_fwd_a/b=00; the same pair separated by one independent instruction -> 1 stall cycle.
- Writes to $0 (addi $0,$0,5 then add $1,$0,$0) and NOP (id_valid=0) traffic -> no stall, selects 00.
- pipe_en=0 for 3 cycles during a load-use stall -> scoreboard, selects and stall_cycles frozen; the stall completes after pipe_en returns to 1.
- Assert reset=0 mid-stall -> outputs 0 and stall_cycles=0 immediately; after release, an ID instruction that previously matched now reports no hazard.
